wb_write_arbiter: RTL and testbench
===================================

# wb_write_arbiter

Shares the single register-file write port between several writeback producers: the ALU/flag path, the load-return path and a multi-cycle multiply unit. It accepts one request per cycle under round-robin priority and registers the winner onto the write port. It also drops writes to r0 and stalls every producer while the register file is busy. It sits between the execute/memory stages and the register file, replacing direct per-stage write enables.

## Interface
Parameters:
- N_REQ, 3, number of requesters (2..8)
- DW, 32, data width
- AW, 5, register address width

Ports (reset: reset, synchronous, active-high; clock: clk):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  N_REQ  per-requester write request
- req_addr  in  N_REQ*AW  destination register; slice i = [i*AW +: AW]
- req_data  in  N_REQ*DW  write data; slice i = [i*DW +: DW]
- req_ready  out  N_REQ  one-hot grant/accept, combinational
- rf_busy  in  1  register file unavailable this cycle; no grant issued
- wr_en  out  1  register-file write enable, registered
- wr_addr  out  AW  register-file write address, registered
- wr_data  out  DW  register-file write data, registered
- stall  out  1  high when any req_valid bit is high and not granted this cycle
- conflict_cnt  out  16  saturating count of cycles with ≥2 valid requests (only with WB_ARB_PERF_EN; otherwise tied to 0)

## Operation
- A transfer on requester i occurs when req_valid[i] && req_ready[i].
- Once asserted, a requester holds req_valid, addr and data stable until accepted.
- At most one req_ready bit is high per cycle. None is high when rf_busy=1 or when no request is valid.
- Arbitration is round-robin. The search starts at pointer rr_ptr and wraps modulo N_REQ. The first valid index found wins.
- After a grant to index g, rr_ptr = (g+1) mod N_REQ. With no grant, rr_ptr holds.
- Same-address override: if two or more valid requests target the same nonzero address in one cycle, the lowest index among them wins. Lower index means the older producer. rr_ptr still updates from the actual winner.
- r0 suppression: a granted request with addr==0 is accepted (req_ready high) but produces wr_en=0 in the next cycle. wr_addr and wr_data hold their previous values in that case.
- Registered write: the cycle after a grant of a nonzero addr, wr_en=1 and wr_addr/wr_data equal the granted slice. wr_en is high for exactly one cycle per accepted nonzero request.
- stall = |req_valid & ~req_ready.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, rr_ptr=0, conflict_cnt=0. The reset condition also forces req_ready=0 in that cycle.
- Reset mid-operation: requests pending at reset are not granted. Producers re-present them after reset deasserts.

## Timing
- Grant latency: 0 cycles. req_ready is decoded combinationally from req_valid, req_addr, rr_ptr and rf_busy.
- Write latency: 1 cycle from acceptance to wr_en.
- Throughput: one accepted request per cycle while rf_busy=0.
- Worst-case wait for a valid requester with rf_busy=0: N_REQ-1 cycles. The same-address override can extend this only while an older producer keeps targeting the same register.
- rf_busy asserted: no grant in that cycle, and rr_ptr holds. wr_en still reflects the grant made in the previous cycle, because that write is already in flight.

## Configuration
- WB_ARB_PERF_EN defined: conflict_cnt increments each cycle in which popcount(req_valid) ≥ 2, independent of rf_busy. It saturates at 16'hFFFF and is cleared only by reset.
- WB_ARB_PERF_EN undefined: the counter logic is absent and conflict_cnt is driven to 16'd0.

## Structure
- Shared package wb_pkg holds:
  - REG_AW=5 and REG_DW=32 constants
  - the R0_ADDR constant
  - the conflict counter width CNT_W=16
- The round-robin priority selector is natural as one sub-module, rr_select. Its inputs are the request vector and rr_ptr; its outputs are a one-hot grant and the encoded index. The top level wraps it with the same-address override and the output registers.

## Test plan
1. Single request: req_valid=3'b001, addr=5'd7, data=32'hDEADBEEF → req_ready=001 in that cycle. Next cycle wr_en=1, wr_addr=7, wr_data=DEADBEEF. rr_ptr becomes 1.
2. All three valid continuously with distinct addrs 1/2/3 from reset → grants in order 0,1,2,0,… with wr_addr 1,2,3,1 on consecutive cycles, and stall=1 every cycle.
3. Same address: req 1 and req 2 both target addr 9, rr_ptr=2 → req 1 granted first and req 2 in the following cycle. The register file sees req 1's data, then req 2's data.
4. r0 write: req 0 addr=0, data=32'h1234 → req_ready[0]=1, then next cycle wr_en=0 and wr_addr/wr_data unchanged.
5. rf_busy=1 for 3 cycles with req_valid=011 → req_ready=00 and stall=1 throughout, rr_ptr unchanged. Grant to the rr_ptr-selected requester on the first cycle after rf_busy falls.
6. Reset asserted while req_valid=111 → wr_en=0, req_ready=000, rr_ptr=0 and conflict_cnt=0 the next cycle. With WB_ARB_PERF_EN, 5 cycles of 2+ valid requests after reset release read conflict_cnt=5.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants for the writeback arbiter slice.
// Holds register-file geometry and the counter width.
package wb_pkg;
   localparam int REG_AW = 5;
   localparam int REG_DW = 32;
   localparam logic [REG_AW-1:0] R0_ADDR = '0;
   localparam int CNT_W = 16;
endpackage

// File: rtl/wb_write_arbiter_rr_select.sv
// Round-robin priority selector: first valid request at or after the pointer,
// wrapping modulo N_REQ. Produces a one-hot grant and its encoded index.
module rr_select #(
   parameter int N_REQ = 3,
   parameter int PW    = 2
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [PW-1:0]    i_ptr,
   output logic [N_REQ-1:0] o_grant,
   output logic [PW-1:0]    o_idx
);
   logic w_found;
   int   w_j;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_j     = 0;
      for (int k = 0; k < N_REQ; k++) begin
         w_j = (int'(i_ptr) + k) % N_REQ;
         if (!w_found && i_req[w_j]) begin
            w_found      = 1'b1;
            o_grant[w_j] = 1'b1;
            o_idx        = PW'(w_j);
         end
      end
   end
endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write port arbiter: round-robin, same-address oldest-wins,
// r0 drop, rf_busy stall. WB_ARB_PERF_EN adds the conflict counter.
module wb_write_arbiter
   import wb_pkg::*;
#(
   parameter int N_REQ = 3,
   parameter int DW    = REG_DW,
   parameter int AW    = REG_AW
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_REQ-1:0]    req_valid,
   input  logic [N_REQ*AW-1:0] req_addr,
   input  logic [N_REQ*DW-1:0] req_data,
   output logic [N_REQ-1:0]    req_ready,
   input  logic                rf_busy,
   output logic                wr_en,
   output logic [AW-1:0]       wr_addr,
   output logic [DW-1:0]       wr_data,
   output logic                stall,
   output logic [CNT_W-1:0]    conflict_cnt
);
   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [PW-1:0]    r_rr_ptr;
   logic             r_wr_en;
   logic [AW-1:0]    r_wr_addr;
   logic [DW-1:0]    r_wr_data;

   logic [N_REQ-1:0] w_rr_grant;
   logic [PW-1:0]    w_rr_idx;
   logic [N_REQ-1:0] w_coll;
   logic [PW-1:0]    w_coll_idx;
   logic             w_coll_any;
   logic [N_REQ-1:0] w_grant;
   logic [PW-1:0]    w_idx;
   logic             w_any;
   logic [AW-1:0]    w_addr;
   logic [DW-1:0]    w_data;
   logic             w_wr;

   rr_select #(
      .N_REQ (N_REQ),
      .PW    (PW)
   ) u_rr (
      .i_req   (req_valid),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_rr_grant),
      .o_idx   (w_rr_idx)
   );

   // A request collides when another valid one targets the same nonzero reg.
   always_comb begin
      w_coll = '0;
      for (int i = 0; i < N_REQ; i++) begin
         for (int j = 0; j < N_REQ; j++) begin
            if (i != j && req_valid[i] && req_valid[j] &&
                req_addr[i*AW +: AW] == req_addr[j*AW +: AW] &&
                req_addr[i*AW +: AW] != AW'(R0_ADDR))
               w_coll[i] = 1'b1;
         end
      end
   end

   always_comb begin
      w_coll_idx = '0;
      w_coll_any = 1'b0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (w_coll[i]) begin
            w_coll_idx = PW'(i);
            w_coll_any = 1'b1;
         end
      end
   end

   always_comb begin
      w_grant = '0;
      w_idx   = w_rr_idx;
      if (!reset && !rf_busy && |req_valid) begin
         if (w_coll_any) begin
            w_idx               = w_coll_idx;
            w_grant[w_coll_idx] = 1'b1;
         end else begin
            w_grant = w_rr_grant;
         end
      end
   end

   assign w_any  = |w_grant;
   assign w_addr = req_addr[int'(w_idx)*AW +: AW];
   assign w_data = req_data[int'(w_idx)*DW +: DW];
   assign w_wr   = w_any && (w_addr != AW'(R0_ADDR));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rr_ptr  <= '0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else begin
         r_wr_en <= w_wr;
         if (w_wr) begin
            r_wr_addr <= w_addr;
            r_wr_data <= w_data;
         end
         if (w_any)
            r_rr_ptr <= (w_idx == PW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
      end
   end

   assign req_ready = w_grant;
   assign stall     = |(req_valid & ~w_grant);
   assign wr_en     = r_wr_en;
   assign wr_addr   = r_wr_addr;
   assign wr_data   = r_wr_data;

`ifdef WB_ARB_PERF_EN
   logic [CNT_W-1:0] r_conflict_cnt;
   logic [3:0]       w_pop;

   always_comb begin
      w_pop = '0;
      for (int i = 0; i < N_REQ; i++)
         w_pop = w_pop + {3'b000, req_valid[i]};
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_conflict_cnt <= '0;
      else if (w_pop >= 4'd2 && r_conflict_cnt != '1)
         r_conflict_cnt <= r_conflict_cnt + 1'b1;
   end

   assign conflict_cnt = r_conflict_cnt;
`else
   assign conflict_cnt = '0;
`endif
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: hand sequences plus a vector table,
// registered writes checked through a per-cycle scoreboard.
module tb_wb_write_arbiter;
   import wb_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  req_valid;
   logic [14:0] req_addr;
   logic [95:0] req_data;
   logic [2:0]  req_ready;
   logic        rf_busy;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        stall;
   logic [15:0] conflict_cnt;

   wb_write_arbiter #(
      .N_REQ (3),
      .DW    (32),
      .AW    (5)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_addr     (req_addr),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .rf_busy      (rf_busy),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .stall        (stall),
      .conflict_cnt (conflict_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       busy;
      logic [2:0] v;
      logic [4:0] a0;
      logic [4:0] a1;
      logic [4:0] a2;
      logic [2:0] er;
      logic       es;
   } vec_t;

   typedef struct {
      logic        en;
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   wr_t         sb[$];
   logic [4:0]  last_a;
   logic [31:0] last_d;
   int          n_chk  = 0;
   int          n_fail = 0;
   vec_t        tbl[17];
   logic [15:0] exp_cnt5;

   function automatic logic [31:0] dat(input int i, input int k);
      return 32'hA000_0000 + (i << 24) + k;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cycle(input logic rst, input logic busy,
                        input logic [2:0] v,
                        input logic [4:0] a0, input logic [4:0] a1,
                        input logic [4:0] a2,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2,
                        input logic [2:0] er, input logic es,
                        input string nm);
      logic [4:0]  aa[3];
      logic [31:0] dd[3];
      wr_t         e;
      int          g;
      aa = '{a0, a1, a2};
      dd = '{d0, d1, d2};
      reset     = rst;
      rf_busy   = busy;
      req_valid = v;
      req_addr  = {a2, a1, a0};
      req_data  = {d2, d1, d0};
      #1;
      chk({nm, "_ready"}, 32'(req_ready), 32'(er));
      chk({nm, "_stall"}, 32'(stall), 32'(es));
      g = -1;
      for (int i = 0; i < 3; i++)
         if (er[i]) g = i;
      if (rst) begin
         e = '{1'b0, 5'd0, 32'd0};
         last_a = '0;
         last_d = '0;
      end else if (g >= 0 && aa[g] != 5'd0) begin
         e = '{1'b1, aa[g], dd[g]};
         last_a = aa[g];
         last_d = dd[g];
      end else begin
         e = '{1'b0, last_a, last_d};
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({nm, "_wr_en"}, 32'(wr_en), 32'(e.en));
      chk({nm, "_wr_addr"}, 32'(wr_addr), 32'(e.a));
      chk({nm, "_wr_data"}, wr_data, e.d);
   endtask

   initial begin
`ifdef WB_ARB_PERF_EN
      exp_cnt5 = 16'd5;
`else
      exp_cnt5 = 16'd0;
`endif
      tbl[0]  = '{1'b1, 1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 3'b000, 1'b1};
      tbl[1]  = '{1'b0, 1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 3'b001, 1'b1};
      tbl[2]  = '{1'b0, 1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 3'b010, 1'b1};
      tbl[3]  = '{1'b0, 1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 3'b100, 1'b1};
      tbl[4]  = '{1'b0, 1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 3'b001, 1'b1};
      tbl[5]  = '{1'b0, 1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 3'b010, 1'b1};
      tbl[6]  = '{1'b0, 1'b0, 3'b110, 5'd0, 5'd9, 5'd9, 3'b010, 1'b1};
      tbl[7]  = '{1'b0, 1'b0, 3'b100, 5'd0, 5'd0, 5'd9, 3'b100, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 3'b111, 5'd5, 5'd6, 5'd6, 3'b010, 1'b1};
      tbl[9]  = '{1'b0, 1'b0, 3'b101, 5'd5, 5'd0, 5'd6, 3'b100, 1'b1};
      tbl[10] = '{1'b0, 1'b0, 3'b001, 5'd5, 5'd0, 5'd0, 3'b001, 1'b0};
      tbl[11] = '{1'b0, 1'b0, 3'b011, 5'd0, 5'd0, 5'd0, 3'b010, 1'b1};
      tbl[12] = '{1'b0, 1'b0, 3'b011, 5'd4, 5'd8, 5'd0, 3'b001, 1'b1};
      tbl[13] = '{1'b0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0};
      tbl[14] = '{1'b0, 1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0};
      tbl[15] = '{1'b0, 1'b1, 3'b100, 5'd0, 5'd0, 5'd3, 3'b000, 1'b1};
      tbl[16] = '{1'b0, 1'b0, 3'b100, 5'd0, 5'd0, 5'd3, 3'b100, 1'b0};

      reset     = 1'b1;
      rf_busy   = 1'b0;
      req_valid = '0;
      req_addr  = '0;
      req_data  = '0;
      last_a    = '0;
      last_d    = '0;
      #1;

      cycle(1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, "reset");
      chk("reset_cnt", 32'(conflict_cnt), 32'd0);
      cycle(0, 0, 3'b001, 7, 0, 0, 32'hDEADBEEF, 0, 0, 3'b001, 0, "single");
      cycle(0, 0, 3'b001, 0, 0, 0, 32'h1234, 0, 0, 3'b001, 0, "r0");
      repeat (3)
         cycle(0, 1, 3'b011, 3, 4, 0, 32'h11, 32'h22, 0, 3'b000, 1, "busy");
      cycle(0, 0, 3'b011, 3, 4, 0, 32'h11, 32'h22, 0, 3'b010, 1, "busy_rel");
      cycle(0, 0, 3'b001, 3, 0, 0, 32'h11, 0, 0, 3'b001, 0, "busy_rest");

      for (int k = 0; k < 17; k++) begin
         cycle(tbl[k].rst, tbl[k].busy, tbl[k].v,
               tbl[k].a0, tbl[k].a1, tbl[k].a2,
               dat(0, k), dat(1, k), dat(2, k),
               tbl[k].er, tbl[k].es, $sformatf("vec%0d", k));
         if (k == 0)
            chk("vec_rst_cnt", 32'(conflict_cnt), 32'd0);
         if (k == 5)
            chk("vec_cnt5", 32'(conflict_cnt), 32'(exp_cnt5));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
